// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the pixel pipeline
// (raster defaults, colour/beat types, sequencer states, colour bars).
package video_pkg;

  localparam int SCREEN_WIDTH_DEF  = 640;
  localparam int SCREEN_HEIGHT_DEF = 480;
  localparam int RGB_W             = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic sof;
    logic eol;
  } pix_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  // Maps a bar index (0 = leftmost) to its colour.
  function automatic rgb_t barColour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// pix_skid_fifo: 2-entry FIFO of pixel beats. Head is the oldest entry;
// the owner guarantees no push when full and no pop when empty.
module pix_skid_fifo
  import video_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  pix_beat_t i_data,
  input  logic      i_pop,
  output pix_beat_t o_head,
  output logic [1:0] o_count
);

  pix_beat_t  r_mem [2];
  logic       r_wrPtr;
  logic       r_rdPtr;
  logic [1:0] r_count;

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (i_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: issues raster coordinates to a registered colour source,
// collects the colours one cycle later into a 2-entry FIFO and emits a
// backpressured pixel stream with sof/eol flags. Frames always run to
// completion; continuous mode restarts at each frame end unless stopped.
// Optional build macro FRAME_SEQ_PATTERN_EN adds test_pattern_i, which
// replaces captured colours with 8 vertical colour bars.
module frame_sequencer
  import video_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int COORD_W       = 11,
  parameter int RGB_SIZE      = RGB_W,
  parameter int FRAME_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   continuous_i,
  output logic                   coord_valid_o,
  output logic [COORD_W-1:0]     x_o,
  output logic [COORD_W-1:0]     y_o,
  input  logic [RGB_SIZE-1:0]    colour_i,
`ifdef FRAME_SEQ_PATTERN_EN
  input  logic                   test_pattern_i,
`endif
  output logic [RGB_SIZE-1:0]    pix_data_o,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic                   pix_sof_o,
  output logic                   pix_eol_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_HEIGHT - 1);

  seq_state_t             r_state;
  seq_state_t             w_stateNext;
  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  logic                   r_stopPend;
  logic                   r_ifValid;
  logic                   r_ifSof;
  logic                   r_ifEol;
  logic [FRAME_CNT_W-1:0] r_frameCnt;
  logic                   r_frameDone;

  logic [1:0]             w_occ;
  logic [2:0]             w_pending;
  logic                   w_pop;
  logic                   w_issue;
  logic                   w_lastPix;
  logic                   w_drained;
  logic                   w_frameEnd;
  rgb_t                   w_captured;
  pix_beat_t              w_pushBeat;
  pix_beat_t              w_head;

  // Issue throttle: a slot is free when FIFO entries plus the in-flight beat,
  // less the beat leaving this cycle, stay below the FIFO depth.
  always_comb begin
    w_pop     = (w_occ != 2'd0) && pix_ready_i;
    w_pending = {1'b0, w_occ} + {2'b00, r_ifValid} - {2'b00, w_pop};
    w_issue   = (r_state == RUN) && (w_pending < 3'd2);
    w_lastPix = (r_x == X_LAST) && (r_y == Y_LAST);
    w_drained = ((w_occ - {1'b0, w_pop}) == 2'd0) && !r_ifValid;
  end

  // Next-state logic; a frame ends when the last beat leaves and nothing is in flight.
  always_comb begin
    w_stateNext = r_state;
    w_frameEnd  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_stateNext = RUN;
      end
      RUN: begin
        if (w_issue && w_lastPix) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (w_drained) begin
          w_frameEnd  = 1'b1;
          w_stateNext = (continuous_i && !r_stopPend) ? RUN : IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Raster counters advance on every issue and rewind at frame end.
  always_ff @(posedge clk) begin
    if (reset || w_frameEnd) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_issue) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  // Stop request: held until the frame ends; a stop on the exit cycle of a
  // continuing frame carries into the next one.
  always_ff @(posedge clk) begin
    if (reset)                            r_stopPend <= 1'b0;
    else if (w_frameEnd)                  r_stopPend <= (w_stateNext == RUN) && stop_i;
    else if (stop_i && r_state != IDLE)   r_stopPend <= 1'b1;
  end

  // In-flight tracker: flags for the coordinate whose colour arrives next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifValid <= 1'b0;
      r_ifSof   <= 1'b0;
      r_ifEol   <= 1'b0;
    end else begin
      r_ifValid <= w_issue;
      if (w_issue) begin
        r_ifSof <= (r_x == '0) && (r_y == '0);
        r_ifEol <= (r_x == X_LAST);
      end
    end
  end

  // Completed-frame counter and its companion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameCnt  <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_frameEnd;
      if (w_frameEnd) r_frameCnt <= r_frameCnt + FRAME_CNT_W'(1);
    end
  end

`ifdef FRAME_SEQ_PATTERN_EN
  localparam logic [COORD_W+2:0] W_EXT = (COORD_W + 3)'(SCREEN_WIDTH);

  logic [COORD_W-1:0] r_ifX;
  logic [COORD_W+2:0] w_barProd;
  logic [2:0]         w_barIdx;

  // Keeps the issued x alongside the in-flight flags for bar selection.
  always_ff @(posedge clk) begin
    if (reset)        r_ifX <= '0;
    else if (w_issue) r_ifX <= r_x;
  end

  // Colour capture with optional bar substitution indexed by (x*8)/width.
  always_comb begin
    w_barProd  = {r_ifX, 3'b000};
    w_barIdx   = 3'(w_barProd / W_EXT);
    w_captured = test_pattern_i ? barColour(w_barIdx) : rgb_t'(colour_i);
  end
`else
  // Colour capture passes the source colour straight through.
  always_comb begin
    w_captured = rgb_t'(colour_i);
  end
`endif

  // Beat assembled from the returning colour and its in-flight flags.
  always_comb begin
    w_pushBeat.rgb = w_captured;
    w_pushBeat.sof = r_ifSof;
    w_pushBeat.eol = r_ifEol;
  end

  pix_skid_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_ifValid),
    .i_data  (w_pushBeat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_occ)
  );

  assign coord_valid_o = w_issue;
  assign x_o           = r_x;
  assign y_o           = r_y;
  assign pix_data_o    = RGB_SIZE'(w_head.rgb);
  assign pix_valid_o   = (w_occ != 2'd0);
  assign pix_sof_o     = w_head.sof;
  assign pix_eol_o     = w_head.eol;
  assign busy_o        = (r_state != IDLE);
  assign frame_done_o  = r_frameDone;
  assign frame_cnt_o   = r_frameCnt;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed and randomized checks of frame_sequencer
// against a raster-order reference model (beat k of the stream is pixel
// (k mod W, (k div W) mod H) with a seeded colour function).
module tb_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int FRAME = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic        pix_ready_i = 1'b1;
  logic [23:0] colour_i = '0;
  logic        coord_valid_o;
  logic [10:0] x_o, y_o;
  logic [23:0] pix_data_o;
  logic        pix_valid_o, pix_sof_o, pix_eol_o, busy_o, frame_done_o;
  logic [15:0] frame_cnt_o;

  int total = 0, bad = 0, cyc = 0;
  int popCnt, issueCnt, doneCnt, lastPopCyc, firstPopCyc, readyMode;
  int stopAtPop;
  bit monOn = 0, stopArm = 0, stopLive = 0, busyAtDone;
  logic [31:0] seed = 32'h1234_5678;
  logic        prevIssue = 0, prevStall = 0, prevSof, prevEol;
  logic [10:0] prevX, prevY;
  logic [23:0] prevData;

  always #5 clk = ~clk;

  frame_sequencer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .coord_valid_o(coord_valid_o),
    .x_o(x_o), .y_o(y_o), .colour_i(colour_i),
`ifdef FRAME_SEQ_PATTERN_EN
    .test_pattern_i(1'b0),
`endif
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .pix_sof_o(pix_sof_o), .pix_eol_o(pix_eol_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

`ifdef FRAME_SEQ_PATTERN_EN
  logic        pStart = 1'b0;
  logic        pCoordValid, pValid, pSof, pEol, pBusy, pDone;
  logic [10:0] pX, pY;
  logic [23:0] pData;
  logic [15:0] pCnt;

  frame_sequencer #(.SCREEN_WIDTH(640), .SCREEN_HEIGHT(1)) pdut (
    .clk(clk), .reset(reset), .start_i(pStart), .stop_i(1'b0),
    .continuous_i(1'b0), .coord_valid_o(pCoordValid), .x_o(pX), .y_o(pY),
    .colour_i(24'h5A5A5A), .test_pattern_i(1'b1),
    .pix_data_o(pData), .pix_valid_o(pValid), .pix_ready_i(1'b1),
    .pix_sof_o(pSof), .pix_eol_o(pEol), .busy_o(pBusy),
    .frame_done_o(pDone), .frame_cnt_o(pCnt)
  );
`endif

  function automatic logic [23:0] srcColour(input int x, input int y);
    logic [31:0] v;
    v = seed + 32'(x) * 32'd37 + 32'(y) * 32'd1031;
    return v[23:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive source colour/ready/armed stop, then check the cycle's outputs.
  task automatic tick();
    bit pop;
    int bx, by;
    @(posedge clk);
    #1;
    cyc++;
    colour_i = prevIssue ? srcColour(int'(prevX), int'(prevY)) : 24'($urandom);
    case (readyMode)
      0:       pix_ready_i = 1'b1;
      1:       pix_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: pix_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (stopArm && popCnt >= stopAtPop) begin
      stop_i = 1'b1; stopArm = 0; stopLive = 1;
    end else if (stopLive) begin
      stop_i = 1'b0; stopLive = 0;
    end
    #1;
    if (!monOn) return;
    pop = pix_valid_o && pix_ready_i;
    if (prevStall) begin
      chk("stall_valid", {31'b0, pix_valid_o}, 1);
      chk("stall_data", {8'b0, pix_data_o}, {8'b0, prevData});
      chk("stall_flags", {30'b0, pix_sof_o, pix_eol_o}, {30'b0, prevSof, prevEol});
    end
    chk("outstanding_le2", {31'b0, (issueCnt - popCnt) <= 2}, 1);
    if (coord_valid_o) begin
      chk("issue_x", {21'b0, x_o}, 32'(issueCnt % W));
      chk("issue_y", {21'b0, y_o}, 32'((issueCnt / W) % H));
      issueCnt++;
    end
    if (frame_done_o) begin
      doneCnt++;
      busyAtDone = busy_o;
      chk("done_after_pop", 32'(cyc), 32'(lastPopCyc + 1));
      chk("done_on_boundary", 32'(popCnt % FRAME), 0);
    end
    chk("frame_cnt", {16'b0, frame_cnt_o}, 32'(doneCnt % 65536));
    if (pop) begin
      bx = popCnt % W;
      by = (popCnt / W) % H;
      chk("beat_data", {8'b0, pix_data_o}, {8'b0, srcColour(bx, by)});
      chk("beat_sof", {31'b0, pix_sof_o}, {31'b0, (bx == 0 && by == 0)});
      chk("beat_eol", {31'b0, pix_eol_o}, {31'b0, (bx == W - 1)});
      if (readyMode == 0 && (popCnt % FRAME) != 0)
        chk("back_to_back", 32'(cyc), 32'(lastPopCyc + 1));
      if (popCnt == 0) firstPopCyc = cyc;
      lastPopCyc = cyc;
      popCnt++;
    end
    prevStall = pix_valid_o && !pix_ready_i;
    prevData  = pix_data_o;
    prevSof   = pix_sof_o;
    prevEol   = pix_eol_o;
    prevIssue = coord_valid_o;
    prevX     = x_o;
    prevY     = y_o;
  endtask

  // Applies a one-cycle reset, checks every output is 0, then clears the model.
  task automatic applyStimulusReset(input string tag);
    monOn = 0; stopArm = 0; stopLive = 0;
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    tick();
    chk({tag, "_rst_coord"}, {31'b0, coord_valid_o}, 0);
    chk({tag, "_rst_xy"}, {10'b0, x_o, y_o}, 0);
    chk({tag, "_rst_data"}, {8'b0, pix_data_o}, 0);
    chk({tag, "_rst_flags"}, {28'b0, pix_valid_o, pix_sof_o, pix_eol_o, busy_o}, 0);
    chk({tag, "_rst_done_cnt"}, {15'b0, frame_done_o, frame_cnt_o}, 0);
    reset = 1'b0;
    popCnt = 0; issueCnt = 0; doneCnt = 0; lastPopCyc = -10; firstPopCyc = -1;
    prevStall = 0; prevIssue = 0; busyAtDone = 1;
    seed = $urandom;
    monOn = 1;
  endtask

  task automatic applyStimulusStart();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Runs until the sequencer is idle and drained, bounded by a cycle budget.
  task automatic checkOutputIdle(input string tag, input int maxCyc);
    int n;
    n = 0;
    while (n < maxCyc && (busy_o || pix_valid_o)) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {30'b0, busy_o, pix_valid_o}, 0);
  endtask

  initial begin
    int startCyc, r, frames, n;
    readyMode = 0;
    applyStimulusReset("init");

    $display("[TB] single frame, ready held high");
    continuous_i = 1'b0;
    startCyc = cyc;
    applyStimulusStart();
    checkOutputIdle("t1", 200);
    chk("t1_latency", 32'(firstPopCyc), 32'(startCyc + 3));
    chk("t1_beats", 32'(popCnt), FRAME);
    chk("t1_dones", 32'(doneCnt), 1);
    chk("t1_cnt", {16'b0, frame_cnt_o}, 1);
    chk("t1_busy_at_done", {31'b0, busyAtDone}, 0);

    $display("[TB] single frame, ready 1,0,0,1");
    applyStimulusReset("t2");
    readyMode = 1;
    applyStimulusStart();
    checkOutputIdle("t2", 300);
    chk("t2_beats", 32'(popCnt), FRAME);
    chk("t2_issues", 32'(issueCnt), FRAME);
    chk("t2_cnt", {16'b0, frame_cnt_o}, 1);

    $display("[TB] single frame, random ready");
    applyStimulusReset("t2r");
    readyMode = 2;
    applyStimulusStart();
    checkOutputIdle("t2r", 400);
    chk("t2r_beats", 32'(popCnt), FRAME);
    chk("t2r_dones", 32'(doneCnt), 1);

    $display("[TB] continuous, stop in frame 2");
    applyStimulusReset("t3");
    readyMode = 0;
    continuous_i = 1'b1;
    stopAtPop = FRAME + 5; stopArm = 1;
    applyStimulusStart();
    checkOutputIdle("t3", 500);
    chk("t3_beats", 32'(popCnt), 2 * FRAME);
    chk("t3_cnt", {16'b0, frame_cnt_o}, 2);
    chk("t3_dones", 32'(doneCnt), 2);

    $display("[TB] continuous, random ready, random stop point");
    for (int k = 0; k < 4; k++) begin
      applyStimulusReset("t3r");
      readyMode = 2;
      continuous_i = 1'b1;
      r = $urandom_range(1, 3 * FRAME - 6);
      frames = r / FRAME + 1;
      stopAtPop = r; stopArm = 1;
      applyStimulusStart();
      checkOutputIdle("t3r", 1500);
      chk("t3r_beats", 32'(popCnt), 32'(frames * FRAME));
      chk("t3r_dones", 32'(doneCnt), 32'(frames));
    end

    $display("[TB] reset mid-frame after beat 5");
    applyStimulusReset("t4");
    readyMode = 0;
    continuous_i = 1'b0;
    applyStimulusStart();
    n = 0;
    while (n < 50 && popCnt < 6) begin
      tick();
      n++;
    end
    chk("t4_reached_beat5", 32'(popCnt), 6);
    applyStimulusReset("t4mid");
    applyStimulusStart();
    checkOutputIdle("t4", 200);
    chk("t4_beats", 32'(popCnt), FRAME);
    chk("t4_cnt", {16'b0, frame_cnt_o}, 1);

    $display("[TB] start+stop together, start while busy");
    applyStimulusReset("t5");
    readyMode = 2;
    continuous_i = 1'b1;
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    stopAtPop = FRAME + 3; stopArm = 1;
    checkOutputIdle("t5", 800);
    chk("t5_beats", 32'(popCnt), 2 * FRAME);
    chk("t5_issues", 32'(issueCnt), 2 * FRAME);
    chk("t5_dones", 32'(doneCnt), 2);

`ifdef FRAME_SEQ_PATTERN_EN
    $display("[TB] colour bar pattern, width 640");
    begin
      int pBeats;
      pBeats = 0;
      pStart = 1'b1;
      @(posedge clk); #2;
      pStart = 1'b0;
      n = 0;
      while (n < 2000 && pBeats < 640) begin
        @(posedge clk); #2;
        if (pValid) begin
          if (pBeats == 0)   chk("pat_x0", {8'b0, pData}, 32'h00FFFFFF);
          if (pBeats == 80)  chk("pat_x80", {8'b0, pData}, 32'h00FFFF00);
          if (pBeats == 639) chk("pat_x639", {8'b0, pData}, 32'h00000000);
          pBeats++;
        end
        n++;
      end
      chk("pat_beats", 32'(pBeats), 640);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
